seg_scan_ctrl: RTL

Scan controller for the four-digit seven-segment display path. It time-multiplexes a 16-bit display word across four digits, inserting a blanking interval at each digit change and a 16-level PWM brightness window. New values arrive over a valid/ready port and are double-buffered, so a value change always takes effect on a frame boundary and never mid-scan. Its digit nibble output feeds the existing nibble-to-segment decoder, and its anode output drives the display directly.

---
 rtl/seg_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller with PWM and double-buffered input
//
// Purpose:
//   Time-multiplexes a 16-bit display word across four digits. Each digit slot
//   is CLK_DIV cycles long. The first BLANK_CYC cycles of a slot are blanked.
//   A 16-level PWM window is applied to the rest of the slot. New words are
//   accepted into a pending buffer and copied to the front buffer only at a
//   frame boundary.
//
// Optional feature (macro SEG_SCAN_LEADZERO_BLANK_EN):
//   Leading-zero suppression. Slot i (i > 0) stays dark when every front
//   nibble at index >= i is zero.
//
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   in_data     : 16-bit display word, nibble i shown on digit i
//   in_valid    : in_data offered
//   in_ready    : pending buffer empty (transfer on in_valid & in_ready)
//   brightness  : PWM level, 0 = 1/16 duty, 15 = full on
//   anodes      : one-hot active-high digit enable, zero while blanked
//   digit_sel   : index of the current slot
//   digit_data  : nibble of the current slot from the front buffer
//   frame_start : one-cycle pulse on cycle 0 of slot 0

module seg_scan_ctrl #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  brightness,
  output logic [3:0]  anodes,
  output logic [1:0]  digit_sel,
  output logic [3:0]  digit_data,
  output logic        frame_start
);

  localparam int              DIV_W       = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] LP_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LP_BLANK    = DIV_W'(BLANK_CYC);
  localparam logic [DIV_W-1:0] LP_ONE      = DIV_W'(1);

  // r_run marks that the first edge after reset release has happened; that
  // edge starts cycle 0 so all outputs can stay registered.
  logic             r_run;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_slot;
  logic [15:0]      r_front;
  logic [15:0]      r_pend;
  logic             r_pend_full;
  logic [3:0]       r_bri;
  logic [3:0]       r_anodes;
  logic [1:0]       r_digit_sel;
  logic [3:0]       r_digit_data;
  logic             r_frame_start;

  logic             w_wrap;
  logic             w_frame_edge;
  logic             w_accept;
  logic             w_swap;
  logic [DIV_W-1:0] w_div_nx;
  logic [1:0]       w_slot_nx;
  logic [15:0]      w_front_nx;
  logic [3:0]       w_bri_nx;
  logic             w_lit;
  logic             w_lz_ok;
  logic [3:0]       w_anodes_nx;
  logic [3:0]       w_digit_nx;
  logic             w_fs_nx;

  // Outputs for the cycle about to start are computed from the next counter,
  // front buffer and brightness values, then registered.
  always_comb begin
    w_wrap       = (r_div_cnt == LP_DIV_LAST);
    w_frame_edge = r_run && w_wrap && (r_slot == 2'd3);
    w_accept     = in_valid && !r_pend_full;
    w_swap       = w_frame_edge && r_pend_full;
    w_div_nx     = (r_run && !w_wrap) ? (r_div_cnt + LP_ONE) : '0;
    w_slot_nx    = (r_run && w_wrap) ? (r_slot + 2'd1) : r_slot;
    w_front_nx   = w_swap ? r_pend : r_front;
    w_bri_nx     = w_frame_edge ? brightness : r_bri;
    w_lit        = (w_div_nx >= LP_BLANK) && (w_div_nx[3:0] <= w_bri_nx);
`ifdef SEG_SCAN_LEADZERO_BLANK_EN
    // Shifting out the lower nibbles leaves exactly the nibbles at index >= slot.
    w_lz_ok      = (w_slot_nx == 2'd0) || ((w_front_nx >> {w_slot_nx, 2'b00}) != 16'h0000);
`else
    w_lz_ok      = 1'b1;
`endif
    w_anodes_nx  = (w_lit && w_lz_ok) ? (4'b0001 << w_slot_nx) : 4'b0000;
    w_digit_nx   = w_front_nx[{w_slot_nx, 2'b00} +: 4];
    w_fs_nx      = (w_div_nx == '0) && (w_slot_nx == 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run         <= 1'b0;
      r_div_cnt     <= '0;
      r_slot        <= 2'd0;
      r_front       <= 16'h0000;
      r_pend        <= 16'h0000;
      r_pend_full   <= 1'b0;
      r_bri         <= 4'hF;
      r_anodes      <= 4'b0000;
      r_digit_sel   <= 2'd0;
      r_digit_data  <= 4'h0;
      r_frame_start <= 1'b0;
    end else begin
      r_run         <= 1'b1;
      r_div_cnt     <= w_div_nx;
      r_slot        <= w_slot_nx;
      r_front       <= w_front_nx;
      r_bri         <= w_bri_nx;
      // Swap only happens with the pending buffer full, when in_ready is low,
      // so accept and swap never coincide.
      if (w_swap) begin
        r_pend_full <= 1'b0;
      end else if (w_accept) begin
        r_pend      <= in_data;
        r_pend_full <= 1'b1;
      end
      r_anodes      <= w_anodes_nx;
      r_digit_sel   <= w_slot_nx;
      r_digit_data  <= w_digit_nx;
      r_frame_start <= w_fs_nx;
    end
  end

  assign in_ready    = !r_pend_full;
  assign anodes      = r_anodes;
  assign digit_sel   = r_digit_sel;
  assign digit_data  = r_digit_data;
  assign frame_start = r_frame_start;

endmodule
